// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, FSM state,
// access context, legality check and byte-strobe generation.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } lsu_state_e;

  // Per-access context captured when a request is accepted.
  typedef struct packed {
    logic       ld;
    logic [2:0] off;
    logic [2:0] funct3;
  } lsu_ctx_t;

  // Conflicting controls, unsigned stores, funct3=111 loads, or a size
  // that does not divide the byte offset.
  function automatic logic lsu_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [2:0] off);
    logic bad;
    bad = rd & wr;
    if (wr & f3[2])           bad = 1'b1;
    if (rd & (f3 == 3'b111))  bad = 1'b1;
    case (f3[1:0])
      SZ_H:    bad = bad | off[0];
      SZ_W:    bad = bad | (|off[1:0]);
      SZ_D:    bad = bad | (|off);
      default: ;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern for a size at a given byte offset.
  function automatic logic [7:0] lsu_strobe(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] s;
    case (sz)
      SZ_B:    s = 8'h01 << off;
      SZ_H:    s = 8'h03 << off;
      SZ_W:    s = 8'h0F << off;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store data/strobe shift toward the byte
// offset, load data shift down then sign/zero extension to 64 bits.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  input  logic [63:0] bus_rdata,
  output logic [63:0] wdata_sh,
  output logic [7:0]  wstrb,
  output logic [63:0] rdata_ext
);

  logic [63:0] rsh;
  logic        uns;

  assign uns = funct3[2];

  // Store lanes and load extraction share the same byte offset.
  always_comb begin
    wdata_sh  = wdata << {off, 3'b000};
    wstrb     = lsu_strobe(funct3[1:0], off);
    rsh       = bus_rdata >> {off, 3'b000};
    rdata_ext = bus_rdata;
    case (funct3[1:0])
      SZ_B:    rdata_ext = uns ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
      SZ_H:    rdata_ext = uns ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      SZ_W:    rdata_ext = uns ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: rdata_ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV64I load/store unit: one access per request over a
// req/ack word bus, with abort on illegal/misaligned access or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [2:0]  funct3,
  output logic [63:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state;
  lsu_ctx_t    ctx;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]  sel_off, sel_f3;
  logic [63:0] wdata_sh, rdata_ext;
  logic [7:0]  wstrb;
  logic        req_any, illegal;

  assign req_any = mem_read | mem_write;
  assign illegal = lsu_illegal(mem_read, mem_write, funct3, addr[2:0]);
  assign stall   = req_any & ~done;

  // The aligner sees live inputs while accepting, the captured context afterwards.
  always_comb begin
    sel_off = (state == S_IDLE) ? addr[2:0] : ctx.off;
    sel_f3  = (state == S_IDLE) ? funct3    : ctx.funct3;
  end

  lsu_data_align u_align (
    .off       (sel_off),
    .funct3    (sel_f3),
    .wdata     (wdata),
    .bus_rdata (mem_rdata),
    .wdata_sh  (wdata_sh),
    .wstrb     (wstrb),
    .rdata_ext (rdata_ext)
  );

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctx       <= '0;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            ctx <= '{ld: mem_read, off: addr[2:0], funct3: funct3};
            if (illegal) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_REQ;
              err       <= 1'b0;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {addr[63:3], 3'b000};
              mem_wdata <= wdata_sh;
              mem_wstrb <= mem_write ? wstrb : 8'h00;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (ctx.ld) rdata <= rdata_ext;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata   <= '0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [2:0]  funct3 = '0;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        done, err, stall, mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] m_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .funct3(funct3), .rdata(rdata), .done(done),
    .err(err), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_illegal(input logic rd, input logic wr,
                                     input logic [63:0] a, input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    if (rd && f3 == 3'b111) return 1'b1;
    return (int'(a[2:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] bus, input logic [63:0] a,
                                         input logic [2:0] f3);
    int n, off;
    logic [63:0] v, mask;
    n = nbytes(f3);
    off = int'(a[2:0]);
    if (n == 8) return bus;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = (bus >> (8 * off)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [2:0] f3);
    logic [15:0] s;
    s = ((16'd1 << nbytes(f3)) - 16'd1) << int'(a[2:0]);
    return s[7:0];
  endfunction

  // One complete access; waits >= TMO means the bus never acknowledges.
  task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] f3,
                        input int waits, input logic [63:0] bus);
    logic bad, acked;
    logic [7:0] s;
    logic [63:0] lm;
    bad = m_illegal(rd, wr, a, f3);
    s = m_strb(a, f3);
    lm = '0;
    acked = 1'b0;
    for (int i = 0; i < 8; i++) lm[8*i +: 8] = {8{s[i]}};
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3; mem_ack = 1'b0;
    @(negedge clk);
    if (bad) begin
      chk("err_done", done, 1);
      chk("err_flag", err, 1);
      chk("err_noreq", mem_req, 0);
      chk("err_rdata", rdata, m_rdata);
    end else begin
      for (int c = 1; c <= TMO; c++) begin
        chk("req", mem_req, 1);
        chk("req_nodone", done, 0);
        chk("stall", stall, 1);
        chk("addr", mem_addr, {a[63:3], 3'b000});
        chk("we", mem_we, wr);
        if (wr) begin
          chk("wstrb", mem_wstrb, s);
          chk("wdata", mem_wdata & lm, (wd << (8 * int'(a[2:0]))) & lm);
        end
        if (c == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = bus; acked = 1'b1;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (acked) break;
      end
      if (acked && rd) m_rdata = m_load(bus, a, f3);
      if (!acked) m_rdata = '0;
      chk("done", done, 1);
      chk("done_err", err, !acked);
      chk("req_drop", mem_req, 0);
      chk("rdata", rdata, m_rdata);
    end
    chk("stall_done", stall, 0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_req", mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rr, ww;
    logic [2:0] f3;
    logic [63:0] a;
    int r;

    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Directed cases
    access(1, 0, 64'h1000, 64'h0, 3'b011, 0, 64'h8877665544332211);
    access(1, 0, 64'h1003, 64'h0, 3'b000, 0, 64'h0000000080000000);
    access(1, 0, 64'h1003, 64'h0, 3'b100, 1, 64'h0000000080000000);
    access(0, 1, 64'h2006, 64'hABCD, 3'b001, 3, 64'h0);
    access(1, 0, 64'h1002, 64'h0, 3'b010, 0, 64'h0);
    access(1, 1, 64'h1000, 64'h0, 3'b011, 0, 64'h0);
    access(0, 1, 64'h1000, 64'h0, 3'b100, 0, 64'h0);
    access(1, 0, 64'h1000, 64'h0, 3'b111, 0, 64'h0);

    // Timeout, then a late ack in IDLE must be ignored
    access(1, 0, 64'h4000, 64'h0, 3'b011, TMO, 64'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_done", done, 0);
    chk("late_ack_req", mem_req, 0);

    // Reset during REQ
    @(negedge clk);
    mem_read = 1'b1; addr = 64'h1000; funct3 = 3'b011;
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_done", done, 0);
    rst_n = 1'b1; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    m_rdata = '0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rst_late_done", done, 0);
    chk("rst_late_req", mem_req, 0);
    chk("rst_rdata0", rdata, m_rdata);
    access(1, 0, 64'h3004, 64'h0, 3'b010, 1, 64'hDEADBEEF_12345678);

    // Randomized accesses
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      rr = (r <= 5); ww = (r == 0) || (r >= 6);
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 7)
        a = a & ~(64'(nbytes(f3)) - 64'd1);
      access(rr, ww, a, {$urandom, $urandom}, f3, $urandom_range(0, 4), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
